// File: rtl/core_pkg.sv
// Shared types and constants for the core control path: sequencer states,
// the trap cause codes and the default reset vector.
package core_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_TRAP
    } pcs_state_t;

    localparam logic [3:0]  CAUSE_IMISALIGN   = 4'd0;
    localparam logic [3:0]  CAUSE_ECALL       = 4'd11;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;

    // Per-cycle decision produced by the next-pc mux.
    typedef struct packed {
        logic       pc_we;      // load pc_next into pc
        logic       retire;     // instruction completes, bump instret
        logic       take_trap;  // save mepc/mcause, enter S_TRAP
        logic [3:0] cause;      // cause to record when take_trap
    } pcs_decision_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-pc priority select: trap > stall > mret > branch > +4,
// plus the vector load performed in S_TRAP.
module pc_next_mux
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  pcs_state_t          state,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     mepc,
    input  logic [XLEN-1:0]     mtvec,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [XLEN-1:0]     br_target,
    input  logic                trap_req,
    input  logic [3:0]          trap_cause,
    input  logic                mret,
    output logic [XLEN-1:0]     pc_next,
    output pcs_decision_t       dec
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    always_comb begin
        pc_next = pc;
        dec     = '0;
        unique case (state)
            S_TRAP: begin
                dec.pc_we = 1'b1;
                pc_next   = mtvec & ALIGN_MASK;
            end
            S_EXEC: begin
                // trap_req outranks stall so exceptions are never held off
                if (trap_req) begin
                    dec.take_trap = 1'b1;
                    dec.cause     = trap_cause;
                end else if (stall) begin
                    dec = '0;
                end else if (mret) begin
                    dec.pc_we  = 1'b1;
                    dec.retire = 1'b1;
                    pc_next    = mepc & ALIGN_MASK;
                end else if (br_taken && (br_target & ~ALIGN_MASK) != '0) begin
                    dec.take_trap = 1'b1;
                    dec.cause     = CAUSE_IMISALIGN;
                end else if (br_taken) begin
                    dec.pc_we  = 1'b1;
                    dec.retire = 1'b1;
                    pc_next    = br_target;
                end else begin
                    dec.pc_we  = 1'b1;
                    dec.retire = 1'b1;
                    pc_next    = pc + XLEN'(4);
                end
            end
            default: begin
                dec = '0;
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetch/execute handshake with instruction memory,
// next-pc arbitration, and the mepc/mcause/instret state.
module pc_sequencer
    import core_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic            cpu_clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_req,
    input  logic [3:0]      trap_cause,
    input  logic            mret,
    input  logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] mepc,
    output logic [3:0]      mcause,
    output logic [63:0]     instret
);

    pcs_state_t      state, state_nxt;
    logic [XLEN-1:0] pc_next;
    pcs_decision_t   dec;

    pc_next_mux #(.XLEN(XLEN)) u_next_mux (
        .state      (state),
        .pc         (pc),
        .mepc       (mepc),
        .mtvec      (mtvec),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .trap_req   (trap_req),
        .trap_cause (trap_cause),
        .mret       (mret),
        .pc_next    (pc_next),
        .dec        (dec)
    );

    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                // a stalled cycle neither traps nor retires, so EXEC holds
                if (dec.take_trap)   state_nxt = S_TRAP;
                else if (dec.retire) state_nxt = S_FETCH;
            end
            S_TRAP:  state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_VEC;
            mepc    <= '0;
            mcause  <= '0;
            instret <= '0;
        end else begin
            if (dec.pc_we)  pc      <= pc_next;
            if (dec.retire) instret <= instret + 64'd1;
            if (dec.take_trap) begin
                mepc   <= pc;
                mcause <= dec.cause;
            end
        end
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer against a behavioural model
// of the fetch/execute sequencing rules.
module tb_pc_sequencer;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap_req;
    logic [3:0]  trap_cause;
    logic        mret;
    logic [31:0] mtvec;
    logic [31:0] pc;
    logic [31:0] mepc;
    logic [3:0]  mcause;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    // model: phase 0 idle, 1 waiting for fetch, 2 executing, 3 vectoring
    int          m_ph;
    logic [31:0] m_pc, m_mepc;
    logic [3:0]  m_mcause;
    logic [63:0] m_instret;

    pc_sequencer dut (
        .cpu_clk     (cpu_clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .trap_req    (trap_req),
        .trap_cause  (trap_cause),
        .mret        (mret),
        .mtvec       (mtvec),
        .pc          (pc),
        .mepc        (mepc),
        .mcause      (mcause),
        .instret     (instret)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic model_reset();
        m_ph = 0; m_pc = 32'h8000_0000; m_mepc = 0; m_mcause = 0; m_instret = 0;
    endtask

    task automatic clear_req();
        stall = 0; br_taken = 0; br_target = 0; trap_req = 0;
        trap_cause = 0; mret = 0;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge.
    task automatic tick();
        @(posedge cpu_clk);
        if (reset) begin
            case (m_ph)
                0: m_ph = 1;
                1: if (imem_ack) m_ph = 2;
                2: begin
                    if (trap_req) begin
                        m_mepc = m_pc; m_mcause = trap_cause; m_ph = 3;
                    end else if (stall) begin
                        m_ph = 2;
                    end else if (mret) begin
                        m_pc = {m_mepc[31:2], 2'b00}; m_instret++; m_ph = 1;
                    end else if (br_taken && br_target[1:0] != 2'b00) begin
                        m_mepc = m_pc; m_mcause = 4'd0; m_ph = 3;
                    end else if (br_taken) begin
                        m_pc = br_target; m_instret++; m_ph = 1;
                    end else begin
                        m_pc = m_pc + 32'd4; m_instret++; m_ph = 1;
                    end
                end
                default: begin
                    m_pc = {mtvec[31:2], 2'b00}; m_ph = 1;
                end
            endcase
        end
        #1;
    endtask

    task automatic goto_exec();
        int n = 0;
        clear_req();
        imem_ack = 1;
        while (!instr_valid && n < 10) begin tick(); n++; end
        checks++;
        if (!instr_valid) begin
            errors++; $display("FAIL goto_exec: instr_valid=%0b after %0d cycles, required 1", instr_valid, n);
        end
    endtask

    task automatic jump_to(input logic [31:0] a);
        goto_exec();
        br_taken = 1; br_target = a;
        tick();
        clear_req();
    endtask

    task automatic test_reset();
        reset = 0; imem_ack = 1; mtvec = 32'h8000_0100; clear_req(); model_reset();
        tick(); tick();
        checks++; if (pc !== 32'h8000_0000 || imem_req !== 0 || instr_valid !== 0) begin
            errors++; $display("FAIL reset_out: pc=%h req=%b vld=%b, required 80000000 0 0", pc, imem_req, instr_valid); end
        checks++; if (mepc !== 0 || mcause !== 0 || instret !== 0) begin
            errors++; $display("FAIL reset_csr: mepc=%h mcause=%0d instret=%0d, required 0", mepc, mcause, instret); end
        reset = 1;
        tick();
        checks++; if (imem_req !== 1 || imem_addr !== 32'h8000_0000) begin
            errors++; $display("FAIL first_fetch: req=%b addr=%h, required 1 80000000", imem_req, imem_addr); end
        tick();
        checks++; if (instr_valid !== 1 || imem_req !== 0) begin
            errors++; $display("FAIL first_exec: vld=%b req=%b, required 1 0", instr_valid, imem_req); end
        tick();
        checks++; if (imem_req !== 1 || imem_addr !== 32'h8000_0004) begin
            errors++; $display("FAIL seq_fetch: req=%b addr=%h, required 1 80000004", imem_req, imem_addr); end
        repeat (4) tick();
        checks++; if (instret !== 64'd3) begin
            errors++; $display("FAIL throughput: instret=%0d, required 3", instret); end
    endtask

    task automatic test_ack_delay();
        logic [31:0] p0 = pc;
        int hi = 0;
        imem_ack = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req === 1 && pc === p0) hi++;
            if (i == 3) imem_ack = 1;
            tick();
        end
        checks++; if (hi != 4) begin
            errors++; $display("FAIL ack_delay_hold: req/pc stable %0d cycles, required 4", hi); end
        tick();
        checks++; if (instr_valid !== 0 || imem_req !== 1 || pc !== p0 + 32'd4) begin
            errors++; $display("FAIL ack_delay_exec: vld=%b req=%b pc=%h, required 0 1 %h", instr_valid, imem_req, pc, p0 + 32'd4); end
    endtask

    task automatic test_branch();
        logic [63:0] ir;
        jump_to(32'h8000_0010); goto_exec();
        ir = instret;
        br_taken = 1; br_target = 32'h8000_0100; tick(); clear_req();
        checks++; if (imem_req !== 1 || imem_addr !== 32'h8000_0100 || instret !== ir + 1) begin
            errors++; $display("FAIL branch: addr=%h instret=%0d, required 80000100 %0d", imem_addr, instret, ir + 1); end
        jump_to(32'h8000_0010); goto_exec();
        ir = instret; mtvec = 32'h8000_0301;
        br_taken = 1; br_target = 32'h8000_0102; tick(); clear_req();
        checks++; if (mepc !== 32'h8000_0010 || mcause !== 4'd0 || instret !== ir) begin
            errors++; $display("FAIL misalign: mepc=%h mcause=%0d instret=%0d, required 80000010 0 %0d", mepc, mcause, instret, ir); end
        tick();
        checks++; if (imem_req !== 1 || imem_addr !== 32'h8000_0300) begin
            errors++; $display("FAIL misalign_vec: req=%b addr=%h, required 1 80000300", imem_req, imem_addr); end
    endtask

    task automatic test_trap_mret();
        jump_to(32'h8000_0020); goto_exec();
        mtvec = 32'h8000_0203;
        trap_req = 1; trap_cause = 4'd11; stall = 1; tick(); clear_req();
        checks++; if (mepc !== 32'h8000_0020 || mcause !== 4'd11) begin
            errors++; $display("FAIL trap: mepc=%h mcause=%0d, required 80000020 11", mepc, mcause); end
        tick();
        checks++; if (imem_req !== 1 || imem_addr !== 32'h8000_0200) begin
            errors++; $display("FAIL trap_vec: req=%b addr=%h, required 1 80000200", imem_req, imem_addr); end
        goto_exec();
        mret = 1; tick(); clear_req();
        checks++; if (imem_req !== 1 || imem_addr !== 32'h8000_0020) begin
            errors++; $display("FAIL mret: req=%b addr=%h, required 1 80000020", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        logic [63:0] ir;
        int frozen = 0;
        jump_to(32'h8000_0040); goto_exec();
        ir = instret;
        br_taken = 1; br_target = 32'h8000_0400; stall = 1;
        repeat (5) begin
            tick();
            if (pc === 32'h8000_0040 && instret === ir && instr_valid === 1) frozen++;
        end
        checks++; if (frozen != 5) begin
            errors++; $display("FAIL stall_hold: frozen %0d cycles, required 5", frozen); end
        stall = 0; tick(); clear_req();
        checks++; if (imem_addr !== 32'h8000_0400 || instret !== ir + 1) begin
            errors++; $display("FAIL stall_release: addr=%h instret=%0d, required 80000400 %0d", imem_addr, instret, ir + 1); end
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFC); goto_exec();
        tick();
        checks++; if (pc !== 32'h0 || imem_req !== 1) begin
            errors++; $display("FAIL pc_wrap: pc=%h req=%b, required 00000000 1", pc, imem_req); end
    endtask

    task automatic test_reset_in_trap();
        goto_exec();
        trap_req = 1; trap_cause = 4'd11; tick(); clear_req();
        #2 reset = 0;
        #1;
        model_reset();
        checks++; if (pc !== 32'h8000_0000 || imem_req !== 0 || instr_valid !== 0) begin
            errors++; $display("FAIL async_reset: pc=%h req=%b vld=%b, required 80000000 0 0", pc, imem_req, instr_valid); end
        checks++; if (mepc !== 0 || mcause !== 0 || instret !== 0) begin
            errors++; $display("FAIL async_reset_csr: mepc=%h mcause=%0d instret=%0d, required 0", mepc, mcause, instret); end
        imem_ack = 1; tick();
        checks++; if (imem_req !== 0 || instr_valid !== 0 || pc !== 32'h8000_0000) begin
            errors++; $display("FAIL reset_ack_ignored: req=%b vld=%b pc=%h", imem_req, instr_valid, pc); end
        reset = 1;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            imem_ack   = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            trap_req   = ($urandom_range(0, 9) == 0);
            trap_cause = 4'($urandom);
            mret       = ($urandom_range(0, 7) == 0);
            br_taken   = ($urandom_range(0, 2) == 0);
            br_target  = $urandom;
            if ($urandom_range(0, 4) != 0) br_target[1:0] = 2'b00;
            mtvec      = $urandom;
            tick();
            checks++;
            if (pc !== m_pc || imem_addr !== m_pc || mepc !== m_mepc || mcause !== m_mcause ||
                instret !== m_instret || imem_req !== (m_ph == 1) || instr_valid !== (m_ph == 2)) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL random[%0d]: pc=%h mepc=%h mcause=%0d instret=%0d req=%b vld=%b, required %h %h %0d %0d %b %b",
                             i, pc, mepc, mcause, instret, imem_req, instr_valid,
                             m_pc, m_mepc, m_mcause, m_instret, m_ph == 1, m_ph == 2);
            end
        end
        clear_req();
    endtask

    initial begin
        test_reset();
        test_ack_delay();
        test_branch();
        test_trap_mret();
        test_stall();
        test_wrap();
        test_reset_in_trap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
